pipeline_fetch_queue: RTL and testbench
=======================================

# pipeline_fetch_queue

Decoupling queue between the fetch stage and decode. It captures each valid instruction/PC pair emitted by fetch into a small circular buffer and presents them in order to decode through a valid/ready handshake. This absorbs decode stalls without losing fetched instructions, and a single `flush` discards all in-flight entries on a redirect.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, width of PC fields.
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `BUBBLE_INSTR`, 32'd90, sentinel encoding for "no instruction"; taken from the shared package.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_instr`  in  32  instruction from fetch; `BUBBLE_INSTR` means no instruction this cycle.
- `in_pc`  in  ADDR_WIDTH  PC of `in_instr`.
- `in_ready`  out  1  queue can accept; fetch holds its PC when low.
- `flush`  in  1  discard all entries (branch/exception redirect).
- `out_instr`  out  32  head instruction, or `BUBBLE_INSTR` when not valid.
- `out_pc`  out  ADDR_WIDTH  head PC, or 0 when not valid.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  decode consumes head this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: `DEPTH` entries of {pc, instr}; head/tail pointers of $clog2(DEPTH) bits wrap modulo `DEPTH`; occupancy counter 0..`DEPTH`.
- Push: `in_ready && in_instr != BUBBLE_INSTR` → write at tail, tail+1.
- Pop: `out_valid && out_ready` → head+1.
- Push and pop in the same cycle → both pointers advance; count unchanged.
- `in_ready = (count != DEPTH)`. It depends on state only and does not look ahead to a same-cycle pop. When full, a push is refused even if a pop occurs.
- `out_valid = (count != 0)`. `out_instr`/`out_pc` come combinationally from the head entry, or `BUBBLE_INSTR`/0 when empty.
- Flush has priority over push and pop. Head, tail and count are cleared; a same-cycle push and pop are both ignored. Entry contents need not be cleared.
- Bubbles (`in_instr == BUBBLE_INSTR`) are never stored, whatever the value of `in_pc`.
- Decode stall (`out_ready=0`) holds the head and its outputs stable.

## Timing
- Reset (asserted low, asynchronous): count=0, head=tail=0. Outputs: `out_valid`=0, `out_instr`=`BUBBLE_INSTR`, `out_pc`=0, `in_ready`=1, `count`=0. Deassertion is synchronous to `clk` at the integrating level.
- Reset mid-operation: all entries are lost immediately and outputs go to reset values without waiting for a clock.
- Latency with the bypass disabled: push at edge N → `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: one push and one pop per cycle.
- Flush at edge N → `out_valid`=0 and `in_ready`=1 in cycle N+1.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When count==0, no flush, and a valid push is present, the input is forwarded combinationally to `out_*` with `out_valid`=1 (zero latency).
  - If `out_ready`=1 in that cycle, the entry is not written and count stays 0. Otherwise it is written normally.
- Not defined: there is no combinational path from `in_*` to `out_*`, and minimum latency is 1 cycle.

## Structure
- Shared package `pipeline_pkg` holds:
  - `BUBBLE_INSTR` constant.
  - `fetch_entry_t` packed struct {pc [63:0], instr [31:0]}, used for the storage array.
- No sub-module. Storage, pointers and control are inline in one module.

## Test plan
- Reset release, no input → `out_valid`=0, `out_instr`=90, `in_ready`=1, `count`=0.
- Push pc 0x0/0x4/0x8 (instr 0x00500093, 0x04113c23, 0x05813083) with `out_ready`=1 → outputs appear in order, one per cycle. Without the bypass each lags by 1 cycle; with it there is 0 lag and `count` stays 0.
- Hold `out_ready`=0 and push 5 instructions with `DEPTH`=4 → `count`=4 and `in_ready`=0 after the 4th; the 5th is not stored; `out_pc` stays 0x0.
- Full queue with simultaneous pop and push attempt → pop occurs, push refused, count=3 next cycle. Then wrap-around: 8 further push/pop pairs are returned in PC order.
- Push 2 entries, then assert `flush` together with a push and `out_ready`=1 → next cycle `count`=0 and `out_valid`=0; the flushed-cycle push is absent.
- Drive `in_instr`=90 for 3 cycles with varying `in_pc` → `count` stays 0. Then assert `reset` low mid-queue between clock edges → outputs go to reset values immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Types and constants shared between the fetch and decode stages.
package pipeline_pkg;

    localparam logic [31:0] BUBBLE_INSTR = 32'd90;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/pipeline_fetch_queue.sv
// Fetch-to-decode decoupling queue: circular buffer with valid/ready output and flush.
// Optional zero-latency empty-queue forwarding is enabled by FETCH_QUEUE_BYPASS_EN.
module pipeline_fetch_queue
    import pipeline_pkg::fetch_entry_t;
#(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DEPTH        = 4,
    parameter logic [31:0] BUBBLE_INSTR = pipeline_pkg::BUBBLE_INSTR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                in_instr,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [31:0]                out_instr,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       occ;
    logic                   push_req;
    logic                   wr_en;
    logic                   pop;
    logic                   bypass;

    assign in_ready = (occ != FULL);
    assign push_req = (in_instr != BUBBLE_INSTR);
    assign count    = occ;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = (occ == '0) && !flush && push_req;
`else
    assign bypass = 1'b0;
`endif

    // A forwarded entry consumed in the same cycle never touches storage.
    assign wr_en = in_ready && push_req && !(bypass && out_ready);
    assign pop   = (occ != '0) && out_ready;

    always_comb begin
        out_valid = 1'b0;
        out_instr = BUBBLE_INSTR;
        out_pc    = '0;
        if (occ != '0) begin
            out_valid = 1'b1;
            out_instr = mem[head].instr;
            out_pc    = ADDR_WIDTH'(mem[head].pc);
        end else if (bypass) begin
            out_valid = 1'b1;
            out_instr = in_instr;
            out_pc    = in_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (wr_en)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            occ <= occ + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en && !flush)
            mem[tail] <= '{pc: 64'(in_pc), instr: in_instr};
    end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Scoreboard bench for pipeline_fetch_queue: directed scenarios followed by random traffic.
module tb_pipeline_fetch_queue;

    localparam int unsigned AW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BUB   = 32'd90;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   in_instr;
    logic [AW-1:0] in_pc;
    logic          in_ready;
    logic          flush;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   mcount = 0;

    pipeline_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .BUBBLE_INSTR(BUB)) dut (
        .clk(clk), .reset(reset), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush), .out_instr(out_instr), .out_pc(out_pc), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model occupancy predicts what the queue must accept.
    task automatic step(input logic [31:0] ins, input logic [63:0] pc, input logic ordy, input logic fl);
        bit acc;
        bit exp_valid;
        @(negedge clk);
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = !fl && (ins != BUB) && (mcount < DEPTH);
        if (fl) sb.delete();
        else if (acc) sb.push_back('{pc: pc, instr: ins});
        #2;
        exp_valid = (mcount > 0);
`ifdef FETCH_QUEUE_BYPASS_EN
        if (mcount == 0 && !fl && ins != BUB) exp_valid = 1'b1;
`endif
        chk("count", 64'(count), 64'(mcount));
        chk("in_ready", 64'(in_ready), 64'(mcount < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (fl) mcount = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (mcount == 0 && acc) mcount = ordy ? 0 : 1;
`endif
        else mcount = mcount + int'(acc) - int'(ordy && mcount > 0);
    endtask

    // Monitor: every handshake pops the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (!out_valid) begin
                    chk("idle_instr", 64'(out_instr), 64'(BUB));
                    chk("idle_pc", out_pc, 64'd0);
                end else if (out_ready && !flush) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pop", 64'(out_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_instr", 64'(out_instr), 64'(e.instr));
                        chk("out_pc", out_pc, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        reset     = 1'b0;
        in_instr  = BUB;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd90);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        repeat (2) step(BUB, 64'd0, 1'b0, 1'b0);

        step(32'h00500093, 64'h0, 1'b1, 1'b0);
        step(32'h04113c23, 64'h4, 1'b1, 1'b0);
        step(32'h05813083, 64'h8, 1'b1, 1'b0);
        repeat (2) step(BUB, 64'h0, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) step(32'h1000 + 32'(i), 64'(4 * i), 1'b0, 1'b0);
        chk("stall_pc", out_pc, 64'h0);
        step(32'h2000, 64'h14, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(32'h3000 + 32'(i), 64'h100 + 64'(4 * i), 1'b1, 1'b0);
        repeat (5) step(BUB, 64'h0, 1'b1, 1'b0);

        step(32'h4000, 64'h200, 1'b0, 1'b0);
        step(32'h4001, 64'h204, 1'b0, 1'b0);
        step(32'h4002, 64'h208, 1'b1, 1'b1);
        step(BUB, 64'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) step(BUB, 64'h500 + 64'(i * 12), 1'b1, 1'b0);

        step(32'h5000, 64'h600, 1'b0, 1'b0);
        step(32'h5001, 64'h604, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_instr", 64'(out_instr), 64'd90);
        chk("mid_rst_pc", out_pc, 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_count", 64'(count), 64'd0);
        sb.delete();
        mcount    = 0;
        in_instr  = BUB;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            ins = ($urandom_range(0, 3) == 0) ? BUB : $urandom();
            step(ins, {$urandom(), $urandom()}, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0);
        end
        repeat (DEPTH + 2) step(BUB, 64'h0, 1'b1, 1'b0);
        chk("drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
